// File: rtl/soc_bus_pkg.sv
// rtl/soc_bus_pkg.sv - shared bus types and defaults for the two-master memory arbiter
package soc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } arb_state_t;

    localparam logic MST_M0 = 1'b0;
    localparam logic MST_M1 = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT   = 255;
    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of two valid/ready masters onto one memory slave,
// with a slave wait timeout that forces an error completion.
module mem_arbiter
    import soc_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
    parameter logic [31:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic [15:0] r_wait_cnt;
    logic        r_last;

    logic        w_busy;
    logic        w_owner_m1;
    logic        w_req_valid;
    logic        w_timeout;
    logic        w_ready;
    logic [31:0] w_rdata;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_owner_m1  = (r_state == ST_BUSY1);
    assign w_req_valid = w_owner_m1 ? m1_valid : m0_valid;
    // s_ready on the timeout cycle takes precedence: the slave answered in time.
    assign w_timeout   = w_busy && w_req_valid && !s_ready && (r_wait_cnt == TIMEOUT_CNT);
    assign w_ready     = w_req_valid && (s_ready || w_timeout);
    assign w_rdata     = w_timeout ? ERR_RDATA : s_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0_valid && m1_valid) begin
                    w_next_state = (r_last == MST_M1) ? ST_BUSY0 : ST_BUSY1;
                end else if (m0_valid) begin
                    w_next_state = ST_BUSY0;
                end else if (m1_valid) begin
                    w_next_state = ST_BUSY1;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                // A master dropping valid mid-transfer abandons it without a ready pulse.
                if (!w_req_valid || w_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wait_cnt <= 16'd0;
            r_last     <= MST_M1;
        end else begin
            if (!w_busy) begin
                r_wait_cnt <= 16'd0;
            end else if (!s_ready) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (w_busy && w_ready) begin
                r_last <= w_owner_m1;
            end
        end
    end

    always_comb begin
        s_valid     = 1'b0;
        s_instr     = 1'b0;
        s_addr      = 32'd0;
        s_wdata     = 32'd0;
        s_wstrb     = 4'd0;
        m0_ready    = 1'b0;
        m0_rdata    = 32'd0;
        m1_ready    = 1'b0;
        m1_rdata    = 32'd0;
        grant       = 2'b00;
        timeout_err = 1'b0;
        // Outputs are gated by resetn so an abort cycle never leaks a ready pulse.
        if (resetn && w_busy) begin
            s_valid     = w_req_valid && !w_timeout;
            s_instr     = w_owner_m1 ? m1_instr : m0_instr;
            s_addr      = w_owner_m1 ? m1_addr  : m0_addr;
            s_wdata     = w_owner_m1 ? m1_wdata : m0_wdata;
            s_wstrb     = w_owner_m1 ? m1_wstrb : m0_wstrb;
            timeout_err = w_timeout;
            if (w_owner_m1) begin
                grant    = 2'b10;
                m1_ready = w_ready;
                m1_rdata = w_rdata;
            end else begin
                grant    = 2'b01;
                m0_ready = w_ready;
                m0_rdata = w_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector table, corner sequences and randomized model check
// for mem_arbiter built with TIMEOUT=4.
module tb_mem_arbiter;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready),
        .grant(grant), .timeout_err(timeout_err)
    );

    typedef struct {
        logic        rn, v0, v1, sr;
        logic [31:0] a0, a1, srd;
        logic [1:0]  gnt;
        logic        sv, r0, r1, te;
        logic [31:0] sa, rd0, rd1;
    } vec_t;

    vec_t tbl[$];
    vec_t seq[$];

    function automatic vec_t mk(input int rn, input int v0, input int v1,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input int sr, input logic [31:0] srd,
                                input int gnt, input int sv, input logic [31:0] sa,
                                input int r0, input logic [31:0] rd0,
                                input int r1, input logic [31:0] rd1, input int te);
        vec_t v;
        v.rn = (rn != 0); v.v0 = (v0 != 0); v.v1 = (v1 != 0); v.sr = (sr != 0);
        v.a0 = a0; v.a1 = a1; v.srd = srd;
        v.gnt = 2'(gnt); v.sv = (sv != 0); v.sa = sa;
        v.r0 = (r0 != 0); v.rd0 = rd0; v.r1 = (r1 != 0); v.rd1 = rd1; v.te = (te != 0);
        return v;
    endfunction

    function automatic vec_t idle(input int rn, input int v0, input int v1,
                                  input logic [31:0] a0, input logic [31:0] a1,
                                  input int sr, input logic [31:0] srd);
        return mk(rn, v0, v1, a0, a1, sr, srd, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic apply_vec(input vec_t v, input string tag, input int idx);
        logic [101:0] got, exp;
        @(posedge clk); #1;
        resetn   = v.rn;
        m0_valid = v.v0; m0_addr = v.a0; m0_instr = 1'b0; m0_wdata = 32'h0A0A0A0A; m0_wstrb = 4'h0;
        m1_valid = v.v1; m1_addr = v.a1; m1_instr = 1'b0; m1_wdata = 32'h0B0B0B0B; m1_wstrb = 4'hF;
        s_ready  = v.sr; s_rdata = v.srd;
        #3;
        got = {grant, s_valid, s_addr, m0_ready, m0_rdata, m1_ready, m1_rdata, timeout_err};
        exp = {v.gnt, v.sv, v.sa, v.r0, v.rd0, v.r1, v.rd1, v.te};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] {gnt,sv,saddr,r0,rd0,r1,rd1,terr} got=%h exp=%h", tag, idx, got, exp);
        end
    endtask

    // Randomized reference state: owner -1 means no transfer in progress.
    int          owner, last, waited;
    bit          pend[2];
    bit          done_prev[2];
    logic        pi[2];
    logic [31:0] pa[2], pw[2];
    logic [3:0]  ps[2];

    initial begin
        resetn = 1'b0;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;

        // single read with two wait cycles
        tbl.push_back(idle(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(idle(1, 1, 0, 'h100, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 'h100, 0, 0, 0, 1, 1, 'h100, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 'h100, 0, 0, 0, 1, 1, 'h100, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 'h100, 0, 1, 'h12345678, 1, 1, 'h100, 1, 'h12345678, 0, 0, 0));
        tbl.push_back(idle(1, 0, 0, 0, 0, 0, 0));
        // ties from reset alternate m0, m1, m0, m1
        tbl.push_back(idle(0, 1, 1, 'h300, 'h400, 0, 0));
        tbl.push_back(idle(1, 1, 1, 'h300, 'h400, 0, 0));
        tbl.push_back(mk(1, 1, 1, 'h300, 'h400, 1, 'h11111111, 1, 1, 'h300, 1, 'h11111111, 0, 0, 0));
        tbl.push_back(idle(1, 1, 1, 'h300, 'h400, 0, 0));
        tbl.push_back(mk(1, 1, 1, 'h300, 'h400, 1, 'h22222222, 2, 1, 'h400, 0, 0, 1, 'h22222222, 0));
        tbl.push_back(idle(1, 1, 1, 'h300, 'h400, 0, 0));
        tbl.push_back(mk(1, 1, 1, 'h300, 'h400, 1, 'h33333333, 1, 1, 'h300, 1, 'h33333333, 0, 0, 0));
        tbl.push_back(idle(1, 0, 1, 0, 'h400, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 'h400, 1, 'h44444444, 2, 1, 'h400, 0, 0, 1, 'h44444444, 0));
        tbl.push_back(idle(1, 0, 0, 0, 0, 0, 0));
        // m1 write held while m0 arrives mid-transfer
        tbl.push_back(idle(1, 0, 1, 0, 'h200, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 'h200, 0, 0, 2, 1, 'h200, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 'h500, 'h200, 0, 0, 2, 1, 'h200, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 'h500, 'h200, 0, 0, 2, 1, 'h200, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 'h500, 'h200, 1, 0, 2, 1, 'h200, 0, 0, 1, 0, 0));
        tbl.push_back(idle(1, 1, 0, 'h500, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 'h500, 0, 1, 'h55555555, 1, 1, 'h500, 1, 'h55555555, 0, 0, 0));
        tbl.push_back(idle(1, 0, 0, 0, 0, 0, 0));
        // dead slave: forced completion on the fifth busy cycle
        tbl.push_back(idle(1, 1, 0, 'h600, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 1, 0, 'h600, 0, 0, 0, 1, 1, 'h600, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 'h600, 0, 0, 'h99999999, 1, 0, 'h600, 1, ERR, 0, 0, 1));
        tbl.push_back(idle(1, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) apply_vec(tbl[i], "tbl", i);

        // s_ready on the timeout cycle wins
        seq.push_back(idle(1, 0, 1, 0, 'h700, 0, 0));
        for (int i = 0; i < 4; i++)
            seq.push_back(mk(1, 0, 1, 0, 'h700, 0, 0, 2, 1, 'h700, 0, 0, 0, 0, 0));
        seq.push_back(mk(1, 0, 1, 0, 'h700, 1, 'hCAFEF00D, 2, 1, 'h700, 0, 0, 1, 'hCAFEF00D, 0));
        seq.push_back(idle(1, 0, 0, 0, 0, 0, 0));
        foreach (seq[i]) apply_vec(seq[i], "race", i);
        seq.delete();

        // reset during BUSY1 after m0 was served last: no ready, next tie to m0
        seq.push_back(idle(1, 1, 0, 'h800, 0, 0, 0));
        seq.push_back(mk(1, 1, 0, 'h800, 0, 1, 'h1, 1, 1, 'h800, 1, 'h1, 0, 0, 0));
        seq.push_back(idle(1, 0, 1, 0, 'h900, 0, 0));
        seq.push_back(mk(1, 0, 1, 0, 'h900, 0, 0, 2, 1, 'h900, 0, 0, 0, 0, 0));
        seq.push_back(idle(0, 0, 1, 0, 'h900, 1, 'h77777777));
        seq.push_back(idle(0, 1, 1, 'hA00, 'h900, 1, 'h77777777));
        seq.push_back(idle(1, 1, 1, 'hA00, 'h900, 0, 0));
        seq.push_back(mk(1, 1, 1, 'hA00, 'h900, 1, 'h5, 1, 1, 'hA00, 1, 'h5, 0, 0, 0));
        foreach (seq[i]) apply_vec(seq[i], "reset", i);

        owner = -1; last = 1; waited = 0;
        for (int m = 0; m < 2; m++) begin pend[m] = 0; done_prev[m] = 0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic          rn, sr, to, vn;
            logic [31:0]   srd;
            logic [1:0]    e_gnt;
            logic          e_sv, e_si, e_te;
            logic [31:0]   e_sa, e_sw;
            logic [3:0]    e_ss;
            logic          e_r[2];
            logic [31:0]   e_rd[2];
            logic [138:0]  got, exp;
            int            n, nx_owner, nx_last, nx_waited;

            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                if (done_prev[m]) pend[m] = 0;
                else if (pend[m] && ($urandom % 64 == 0)) pend[m] = 0;
                if (!pend[m]) begin
                    pa[m] = $urandom; pw[m] = $urandom; ps[m] = 4'($urandom); pi[m] = 1'($urandom);
                    if ($urandom % 3 == 0) pend[m] = 1;
                end
            end
            rn  = (cyc < 2) ? 1'b0 : ($urandom % 150 != 0);
            sr  = ($urandom % 8 < 2);
            srd = $urandom;
            resetn = rn; s_ready = sr; s_rdata = srd;
            m0_valid = pend[0]; m0_instr = pi[0]; m0_addr = pa[0]; m0_wdata = pw[0]; m0_wstrb = ps[0];
            m1_valid = pend[1]; m1_instr = pi[1]; m1_addr = pa[1]; m1_wdata = pw[1]; m1_wstrb = ps[1];

            e_gnt = 0; e_sv = 0; e_si = 0; e_sa = 0; e_sw = 0; e_ss = 0; e_te = 0;
            e_r[0] = 0; e_r[1] = 0; e_rd[0] = 0; e_rd[1] = 0;
            nx_owner = owner; nx_last = last; nx_waited = waited;
            if (!rn) begin
                nx_owner = -1; nx_last = 1; nx_waited = 0;
            end else if (owner < 0) begin
                if (pend[0] && pend[1]) nx_owner = (last == 1) ? 0 : 1;
                else if (pend[0]) nx_owner = 0;
                else if (pend[1]) nx_owner = 1;
                nx_waited = 0;
            end else begin
                n  = owner;
                vn = pend[n];
                to = vn && !sr && (waited == TO);
                e_gnt = (n == 0) ? 2'b01 : 2'b10;
                e_si = pi[n]; e_sa = pa[n]; e_sw = pw[n]; e_ss = ps[n];
                e_sv = vn && !to;
                e_r[n] = vn && (sr || to);
                e_rd[n] = to ? ERR : srd;
                e_te = to;
                if (!vn) nx_owner = -1;
                else if (sr || to) begin nx_owner = -1; nx_last = n; end
                else nx_waited = waited + 1;
            end

            #3;
            got = {grant, s_valid, s_instr, s_addr, s_wdata, s_wstrb,
                   m0_ready, m0_rdata, m1_ready, m1_rdata, timeout_err};
            exp = {e_gnt, e_sv, e_si, e_sa, e_sw, e_ss, e_r[0], e_rd[0], e_r[1], e_rd[1], e_te};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL rand[%0d] {gnt,sv,si,sa,sw,ss,r0,rd0,r1,rd1,terr} got=%h exp=%h",
                         cyc, got, exp);
            end
            owner = nx_owner; last = nx_last; waited = nx_waited;
            done_prev[0] = e_r[0];
            done_prev[1] = e_r[1];
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of slave wait cycles before a forced error completion (range 1..65535).
REQ-002 SHALL have parameter ERR_RDATA, default 32'hDEADBEEF, meaning the read data returned on a timeout completion.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports m0_valid/m0_instr in 1, m0_addr in 32, m0_wdata in 32, m0_wstrb in 4, m0_rdata out 32, m0_ready out 1  master 0 (CPU), native valid/ready memory bus.
REQ-006 SHALL have ports m1_valid/m1_instr in 1, m1_addr in 32, m1_wdata in 32, m1_wstrb in 4, m1_rdata out 32, m1_ready out 1  master 1 (loader/DMA), same protocol.
REQ-007 SHALL have ports s_valid/s_instr out 1, s_addr out 32, s_wdata out 32, s_wstrb out 4, s_rdata in 32, s_ready in 1  shared slave (RAM) side.
REQ-008 SHALL have port grant  output  2  one-hot current owner (bit0 = m0, bit1 = m1); 2'b00 when idle.
REQ-009 SHALL have port timeout_err  output  1  one-cycle pulse on a forced timeout completion.

Function
REQ-010 SHALL implement states IDLE, BUSY0, BUSY1; grant SHALL be 2'b01 in BUSY0, 2'b10 in BUSY1, and 2'b00 in IDLE.
REQ-011 In IDLE, s_valid SHALL be 0, both mN_ready SHALL be 0, and the s_* request outputs SHALL be 0.
REQ-012 In IDLE with exactly one mN_valid high, the next state SHALL be BUSYN.
REQ-013 In IDLE with both valid, the next state SHALL grant the master not served last (round-robin); after reset the first tie SHALL go to m0.
REQ-014 Arbitration latency SHALL be exactly one cycle: s_valid rises the cycle after mN_valid is first seen in IDLE.
REQ-015 In BUSYN, the s_* request signals SHALL combinationally equal mN_*, mN_rdata SHALL equal s_rdata, and mN_ready SHALL equal s_ready.
REQ-016 The non-granted master SHALL see ready=0 and rdata=0.
REQ-017 In BUSYN, s_ready=1 SHALL complete the transfer: the next state is IDLE and the last-served master is N.
REQ-018 The grant SHALL never change mid-transfer; a request from the other master waits and is not lost.
REQ-019 A 16-bit wait counter SHALL clear on entry to BUSYN and increment on each BUSYN cycle with s_ready=0.
REQ-020 When the counter equals TIMEOUT with s_ready=0, that cycle SHALL force mN_ready=1, mN_rdata=ERR_RDATA, s_valid=0, timeout_err=1, with next state IDLE and last-served=N.
REQ-021 If s_ready=1 and the timeout occur in the same cycle, s_ready SHALL win: normal completion, no timeout_err.
REQ-022 If mN_valid drops while in BUSYN (protocol violation), the arbiter SHALL return to IDLE next cycle with no ready pulse and without updating last-served.
REQ-023 The arbiter SHALL wait one IDLE cycle between back-to-back transfers (min 1 idle cycle).

Reset
REQ-024 When resetn=0 at a clock edge, the state SHALL become IDLE, the counter 0, last-served=m1 (so m0 wins the first tie), and timeout_err 0.
REQ-025 Reset asserted mid-transfer SHALL abort the transfer: no ready pulse to either master, and s_valid=0 from the next cycle.
REQ-026 All outputs SHALL be 0 while in reset.

Structure
REQ-027 Shared package soc_bus_pkg SHALL hold the state enum, master-id constants, and the default ERR_RDATA/TIMEOUT values.
REQ-028 The design SHALL be one flat module with no sub-module; the request mux is inline.

Verification
REQ-029 Scenario: m0 reads 0x100, slave ready after 2 cycles with s_rdata=0x12345678 -> grant=01, m0_rdata=0x12345678, m0_ready pulses once.
REQ-030 Scenario: m0 and m1 both valid from reset -> m0 served first, then m1 after 1 idle cycle; repeat both -> m0 then m1 again (alternation holds).
REQ-031 Scenario: m1 write addr 0x200 wstrb 0xF while m0 requests mid-transfer -> m1 completes, then m0 is granted; s_addr never glitches during m1's transfer.
REQ-032 Scenario: TIMEOUT=4 and slave never ready -> on the 5th BUSY cycle m0_ready=1, m0_rdata=0xDEADBEEF, timeout_err=1 for one cycle, state returns to IDLE.
REQ-033 Scenario: s_ready arrives exactly on the timeout cycle -> normal data is returned and timeout_err=0.
REQ-034 Scenario: resetn=0 during BUSY1 -> no m1_ready; the next tie goes to m0; all outputs are 0 while in reset.
